// File: rtl/mux_rr_nto1.sv
// mux_rr_nto1: N-to-1 registered multiplexer with fixed select or round-robin arbitration.
// Round-robin arbitration and its pointer are built only when MUX_RR_EN is defined.
module mux_rr_nto1 #(
   parameter int WIDTH  = 4,
   parameter int NUM_IN = 5,
   parameter int CTRL_W = 3
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_mode,
   input  logic [CTRL_W-1:0]       i_ctrl,
   input  logic [NUM_IN-1:0]       i_vld,
   input  logic [NUM_IN*WIDTH-1:0] i_dat,
   output logic [NUM_IN-1:0]       o_ack,
   input  logic                    i_rdy,
   output logic                    o_vld,
   output logic [WIDTH-1:0]        o_dat,
   output logic [CTRL_W-1:0]       o_ch
);

   logic              vld_q, vld_d;
   logic [WIDTH-1:0]  dat_q, dat_d;
   logic [CTRL_W-1:0] ch_q, ch_d;
   logic              load;
   logic              gnt_any;
   logic [CTRL_W-1:0] gnt_idx;
   logic [NUM_IN-1:0] gnt_oh;
   logic [WIDTH-1:0]  gnt_dat;

`ifdef MUX_RR_EN
   logic [CTRL_W-1:0] ptr_q, ptr_d;
`else
   logic unused_mode;
   assign unused_mode = i_mode;
`endif

   assign load = !vld_q || i_rdy;

   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      gnt_oh  = '0;
      gnt_dat = '0;
      if (i_rst_n && load) begin
`ifdef MUX_RR_EN
         if (i_mode) begin
            // First pass covers ptr..NUM_IN-1; second pass picks up the wrap to 0..ptr-1.
            for (int unsigned k = 0; k < NUM_IN; k++) begin
               if (!gnt_any && i_vld[k] && (CTRL_W'(k) >= ptr_q)) begin
                  gnt_any = 1'b1;
                  gnt_idx = CTRL_W'(k);
               end
            end
            for (int unsigned k = 0; k < NUM_IN; k++) begin
               if (!gnt_any && i_vld[k]) begin
                  gnt_any = 1'b1;
                  gnt_idx = CTRL_W'(k);
               end
            end
         end else
`endif
         begin
            for (int unsigned k = 0; k < NUM_IN; k++) begin
               if (!gnt_any && i_vld[k] && (CTRL_W'(k) == i_ctrl)) begin
                  gnt_any = 1'b1;
                  gnt_idx = CTRL_W'(k);
               end
            end
         end
      end
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (gnt_any && (gnt_idx == CTRL_W'(k))) begin
            gnt_oh[k] = 1'b1;
            gnt_dat   = i_dat[k*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      ch_d  = ch_q;
      if (load) begin
         vld_d = gnt_any;
         if (gnt_any) begin
            dat_d = gnt_dat;
            ch_d  = gnt_idx;
         end
      end
   end

`ifdef MUX_RR_EN
   always_comb begin
      ptr_d = ptr_q;
      if (i_mode && gnt_any) begin
         ptr_d = (gnt_idx == CTRL_W'(NUM_IN - 1)) ? '0 : gnt_idx + CTRL_W'(1);
      end
   end
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         vld_q <= 1'b0;
         dat_q <= '0;
         ch_q  <= '0;
`ifdef MUX_RR_EN
         ptr_q <= '0;
`endif
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
         ch_q  <= ch_d;
`ifdef MUX_RR_EN
         ptr_q <= ptr_d;
`endif
      end
   end

   assign o_ack = gnt_oh;
   assign o_vld = vld_q;
   assign o_dat = dat_q;
   assign o_ch  = ch_q;

endmodule

// File: tb/tb_mux_rr_nto1.sv
// Self-checking bench for mux_rr_nto1 against a transaction-level reference model.
// Round-robin expectations apply only when MUX_RR_EN is defined; otherwise i_mode is ignored.
module tb_mux_rr_nto1;

   localparam int W  = 4;
   localparam int N  = 5;
   localparam int CW = 3;

   logic            i_clk = 1'b0;
   logic            i_rst_n;
   logic            i_mode;
   logic [CW-1:0]   i_ctrl;
   logic [N-1:0]    i_vld;
   logic [N*W-1:0]  i_dat;
   logic [N-1:0]    o_ack;
   logic            i_rdy;
   logic            o_vld;
   logic [W-1:0]    o_dat;
   logic [CW-1:0]   o_ch;

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit          m_vld;
   bit [W-1:0]  m_dat;
   bit [CW-1:0] m_ch;
   int          m_ptr;
   int          exp_g;
   bit          exp_rr;
   bit [N-1:0]  exp_ack;

   mux_rr_nto1 #(.WIDTH(W), .NUM_IN(N), .CTRL_W(CW)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode), .i_ctrl(i_ctrl),
      .i_vld(i_vld), .i_dat(i_dat), .o_ack(o_ack), .i_rdy(i_rdy),
      .o_vld(o_vld), .o_dat(o_dat), .o_ch(o_ch)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   function automatic bit vld_bit(input int idx);
      return ((i_vld >> idx) & 5'b1) != 5'b0;
   endfunction

   // Grant decision from the rules: rotate-search from ptr in RR mode, direct select otherwise.
   task automatic predict();
      exp_g  = -1;
      exp_rr = 1'b0;
`ifdef MUX_RR_EN
      exp_rr = i_mode;
`endif
      if (i_rst_n && (!m_vld || i_rdy)) begin
         if (exp_rr) begin
            for (int off = 0; off < N; off++) begin
               if (exp_g < 0 && vld_bit((m_ptr + off) % N)) exp_g = (m_ptr + off) % N;
            end
         end else if (int'(i_ctrl) < N && vld_bit(int'(i_ctrl))) begin
            exp_g = int'(i_ctrl);
         end
      end
      exp_ack = (exp_g >= 0) ? 5'(32'd1 << exp_g) : 5'b0;
   endtask

   task automatic drive(input logic rst_n, input logic mode, input logic [CW-1:0] ctrl,
                        input logic [N-1:0] vld, input logic [N*W-1:0] dat, input logic rdy);
      @(negedge i_clk);
      i_rst_n = rst_n; i_mode = mode; i_ctrl = ctrl; i_vld = vld; i_dat = dat; i_rdy = rdy;
      #1;
      predict();
   endtask

   task automatic clock_edge();
      @(posedge i_clk);
      if (!i_rst_n) begin
         m_vld = 1'b0; m_dat = '0; m_ch = '0; m_ptr = 0;
      end else if (!m_vld || i_rdy) begin
         if (exp_g >= 0) begin
            m_vld = 1'b1;
            m_dat = W'(i_dat >> (exp_g * W));
            m_ch  = CW'(exp_g);
            if (exp_rr) m_ptr = (exp_g + 1) % N;
         end else begin
            m_vld = 1'b0;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 3'd0, 5'b11111, 20'h54321, 1'b1);
         total++;
         if (o_ack !== 5'b0) begin bad++; $display("FAIL reset_ack got=%b want=00000", o_ack); end
         clock_edge();
      end
      total++;
      if ({o_vld, o_dat, o_ch} !== 8'h00) begin
         bad++; $display("FAIL reset_out got vld=%b dat=%h ch=%0d want 0/0/0", o_vld, o_dat, o_ch);
      end
   endtask

   task automatic test_fixed();
      drive(1'b1, 1'b0, 3'd2, 5'b00100, 20'h00A00, 1'b1);
      total++;
      if (o_ack !== 5'b00100) begin bad++; $display("FAIL fixed_ack got=%b want=00100", o_ack); end
      clock_edge();
      total++;
      if ({o_vld, o_dat, o_ch} !== {1'b1, 4'hA, 3'd2}) begin
         bad++; $display("FAIL fixed_out got vld=%b dat=%h ch=%0d want 1/a/2", o_vld, o_dat, o_ch);
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0]  hold_dat;
      logic [CW-1:0] hold_ch;
      logic [N*W-1:0] d;
      drive(1'b1, 1'b0, 3'd1, 5'b00010, 20'h000B0, 1'b1);
      clock_edge();
      hold_dat = m_dat; hold_ch = m_ch;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'($urandom), CW'($urandom_range(0, 4)), 5'b11111, 20'($urandom), 1'b0);
         total++;
         if (o_ack !== 5'b0) begin bad++; $display("FAIL bp_ack got=%b want=00000", o_ack); end
         clock_edge();
         total++;
         if ({o_vld, o_dat, o_ch} !== {1'b1, hold_dat, hold_ch}) begin
            bad++; $display("FAIL bp_hold got vld=%b dat=%h ch=%0d want 1/%h/%0d", o_vld, o_dat, o_ch, hold_dat, hold_ch);
         end
      end
      d = 20'($urandom);
      drive(1'b1, 1'b0, 3'd3, 5'b01000, d, 1'b1);
      clock_edge();
      total++;
      if ({o_vld, o_dat, o_ch} !== {1'b1, d[15:12], 3'd3}) begin
         bad++; $display("FAIL bp_release got vld=%b dat=%h ch=%0d want 1/%h/3", o_vld, o_dat, o_ch, d[15:12]);
      end
      // reset while a word is held under backpressure discards it
      drive(1'b1, 1'b0, 3'd0, 5'b00001, 20'h00007, 1'b0);
      clock_edge();
      drive(1'b0, 1'b0, 3'd0, 5'b11111, 20'hFFFFF, 1'b0);
      total++;
      if (o_ack !== 5'b0) begin bad++; $display("FAIL midrst_ack got=%b want=00000", o_ack); end
      clock_edge();
      total++;
      if ({o_vld, o_dat, o_ch} !== 8'h00) begin
         bad++; $display("FAIL midrst_out got vld=%b dat=%h ch=%0d want 0/0/0", o_vld, o_dat, o_ch);
      end
   endtask

   task automatic test_round_robin();
      int seq [6] = '{0, 1, 2, 3, 4, 0};
      drive(1'b0, 1'b1, 3'd0, 5'b0, 20'h0, 1'b1);
      clock_edge();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b1, 3'd0, 5'b11111, 20'h54321, 1'b1);
         total++;
         if (o_ack !== exp_ack) begin bad++; $display("FAIL rr_ack[%0d] got=%b want=%b", i, o_ack, exp_ack); end
         clock_edge();
         total++;
         if ({o_vld, o_dat, o_ch} !== {m_vld, m_dat, m_ch}) begin
            bad++; $display("FAIL rr_model[%0d] got %b/%h/%0d want %b/%h/%0d", i, o_vld, o_dat, o_ch, m_vld, m_dat, m_ch);
         end
`ifdef MUX_RR_EN
         total++;
         if (int'(o_ch) != seq[i] || int'(o_dat) != seq[i] + 1) begin
            bad++; $display("FAIL rr_seq[%0d] got ch=%0d dat=%0d want ch=%0d dat=%0d", i, o_ch, o_dat, seq[i], seq[i] + 1);
         end
`endif
      end
   endtask

   task automatic test_wrap_skip();
      logic [N-1:0] vseq [3] = '{5'b01000, 5'b01001, 5'b11111};
      drive(1'b0, 1'b1, 3'd0, 5'b0, 20'h0, 1'b1);
      clock_edge();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 3'd0, vseq[i], 20'h9ABCD, 1'b1);
         total++;
         if (o_ack !== exp_ack) begin bad++; $display("FAIL wrap_ack[%0d] got=%b want=%b", i, o_ack, exp_ack); end
`ifdef MUX_RR_EN
         if (i == 1) begin
            total++;
            if (o_ack !== 5'b00001) begin bad++; $display("FAIL wrap_skip got=%b want=00001", o_ack); end
         end
         if (i == 2) begin
            total++;
            if (o_ack !== 5'b00010) begin bad++; $display("FAIL wrap_ptr got=%b want=00010", o_ack); end
         end
`endif
         clock_edge();
         total++;
         if ({o_vld, o_dat, o_ch} !== {m_vld, m_dat, m_ch}) begin
            bad++; $display("FAIL wrap_out[%0d] got %b/%h/%0d want %b/%h/%0d", i, o_vld, o_dat, o_ch, m_vld, m_dat, m_ch);
         end
      end
   endtask

   task automatic test_invalid_sel();
      drive(1'b1, 1'b0, 3'd1, 5'b11111, 20'h12345, 1'b1);
      clock_edge();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, (i == 0) ? 3'd5 : 3'd7, 5'b11111, 20'($urandom), 1'b1);
         total++;
         if (o_ack !== 5'b0) begin bad++; $display("FAIL inv_ack[%0d] got=%b want=00000", i, o_ack); end
         clock_edge();
         total++;
         if ({o_vld, o_dat, o_ch} !== {1'b0, 4'h4, 3'd1}) begin
            bad++; $display("FAIL inv_out[%0d] got %b/%h/%0d want 0/4/1", i, o_vld, o_dat, o_ch);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         drive(1'($urandom_range(0, 39) != 0), 1'($urandom), CW'($urandom), N'($urandom),
               20'($urandom), 1'($urandom_range(0, 3) != 0));
         total++;
         if (o_ack !== exp_ack) begin bad++; $display("FAIL rand_ack[%0d] got=%b want=%b", i, o_ack, exp_ack); end
         clock_edge();
         total++;
         if ({o_vld, o_dat, o_ch} !== {m_vld, m_dat, m_ch}) begin
            bad++; $display("FAIL rand_out[%0d] got %b/%h/%0d want %b/%h/%0d", i, o_vld, o_dat, o_ch, m_vld, m_dat, m_ch);
         end
      end
   endtask

   initial begin
      i_rst_n = 1'b0; i_mode = 1'b0; i_ctrl = '0; i_vld = '0; i_dat = '0; i_rdy = 1'b0;
      m_vld = 1'b0; m_dat = '0; m_ch = '0; m_ptr = 0;
      test_reset();
      test_fixed();
      test_backpressure();
      test_round_robin();
      test_wrap_skip();
      test_invalid_sel();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_rr_nto1.md
MUX_RR_NTO1 -- requirements
Module: mux_rr_nto1

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width per channel.
REQ-002 SHALL have parameter NUM_IN, default 5, number of input channels (2..16).
REQ-003 SHALL have parameter CTRL_W, default 3, select/channel-index width (2**CTRL_W >= NUM_IN).
REQ-004 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_mode  input  1  0 = fixed select via i_ctrl, 1 = round-robin.
REQ-007 SHALL have port i_ctrl  input  CTRL_W  channel select in fixed mode.
REQ-008 SHALL have port i_vld  input  NUM_IN  per-channel data valid.
REQ-009 SHALL have port i_dat  input  NUM_IN*WIDTH  packed channels, channel k at bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port o_ack  output  NUM_IN  one-hot, combinational, channel consumed this cycle.
REQ-011 SHALL have port i_rdy  input  1  downstream ready.
REQ-012 SHALL have port o_vld  output  1  registered output valid.
REQ-013 SHALL have port o_dat  output  WIDTH  registered selected data.
REQ-014 SHALL have port o_ch  output  CTRL_W  registered index of source channel.

Function
REQ-015 SHALL define load = (!o_vld || i_rdy); output register updates only when load is 1.
REQ-016 SHALL, in fixed mode, grant channel i_ctrl when i_ctrl < NUM_IN, i_vld[i_ctrl] = 1 and load = 1.
REQ-017 SHALL, in fixed mode with i_ctrl >= NUM_IN, grant nothing and assert no o_ack.
REQ-018 SHALL, in round-robin mode, grant the first channel with i_vld set, searching from pointer ptr upward and wrapping from NUM_IN-1 to 0, when load = 1.
REQ-019 SHALL set ptr to (grant+1) mod NUM_IN after each round-robin grant; ptr holds when no grant occurs or in fixed mode.
REQ-020 SHALL drive o_ack[g] = 1 in the same cycle as grant g, all other bits 0; at most one bit set.
REQ-021 SHALL, on grant g, load o_dat = channel g data, o_ch = g, o_vld = 1 on the next edge (latency 1 cycle).
REQ-022 SHALL, when load = 1 and no grant, clear o_vld on the next edge; o_dat and o_ch hold their values.
REQ-023 SHALL, when o_vld = 1 and i_rdy = 0, hold o_vld, o_dat and o_ch stable and keep o_ack = 0.
REQ-024 SHALL support back-to-back transfers: o_vld = 1 with i_rdy = 1 and a grant gives a new word every cycle.
REQ-025 SHALL apply an i_mode change at the next grant decision; ptr is not reset by a mode change.

Reset
REQ-026 SHALL, while i_rst_n = 0 at a clock edge, set o_vld = 0, o_dat = 0, o_ch = 0 and ptr = 0.
REQ-027 SHALL force o_ack = 0 while i_rst_n = 0.
REQ-028 SHALL discard a word held in the output register when reset is asserted mid-transfer.

Configuration
REQ-029 SHALL compile round-robin logic only when macro MUX_RR_EN is defined.
REQ-030 SHALL, without MUX_RR_EN, ignore i_mode, operate in fixed mode only and omit ptr; all other behaviour is unchanged.

Verification (defaults WIDTH=4, NUM_IN=5)
REQ-031 SHALL cover reset: i_rst_n = 0 for 3 cycles, i_vld = 5'b11111 -> o_vld = 0, o_dat = 0, o_ch = 0, o_ack = 0.
REQ-032 SHALL cover fixed select: i_mode = 0, i_ctrl = 2, i_vld = 5'b00100, ch2 = 4'hA, i_rdy = 1 -> o_ack = 5'b00100 same cycle; next cycle o_vld = 1, o_dat = 4'hA, o_ch = 2.
REQ-033 SHALL cover backpressure: o_vld = 1, i_rdy = 0 for 3 cycles while inputs change -> o_dat, o_ch and o_vld stable, o_ack = 0; i_rdy = 1 -> next word loads one cycle later.
REQ-034 SHALL cover round-robin: i_mode = 1, i_vld = 5'b11111, channel k data = k+1, i_rdy = 1 -> o_ch sequence 0,1,2,3,4,0 and o_dat sequence 1,2,3,4,5,1.
REQ-035 SHALL cover wrap and skip: ptr = 4 after a grant to channel 3, i_vld = 5'b01001 -> grant channel 0, ptr = 1.
REQ-036 SHALL cover an invalid select: i_mode = 0, i_ctrl = 5, all valid -> o_ack = 0 and o_vld = 0 after the held word drains; bench compares against a golden model every cycle and reports the error count.
